riscv_mc_ctrl: RTL and testbench
================================

RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter NUM_INST.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RSTn  input  1  reset, synchronous, active-low.
REQ-004 OPCODE  input  7  opcode field of the instruction register (IR), valid from ID onward.
REQ-005 BR_TAKEN  input  1  branch comparator result, valid in EX.
REQ-006 HALT_REQ  input  1  halt condition from the datapath (e.g. JALR with rs1 value 0x0000000C), sampled in ID.
REQ-007 D_MEM_RDY  input  1  data memory ready; used only with MEM_WAIT_EN.
REQ-008 IR_WE  output  1  load IR from I_MEM_DI.
REQ-009 PC_WE  output  1  load PC from the PC mux.
REQ-010 PC_SRC  output  2  PC mux select: 00 PC+4, 01 branch target, 10 JAL target, 11 JALR target.
REQ-011 RF_WE  output  1  register file write enable.
REQ-012 D_MEM_WEN  output  1  data memory write enable, active-low.
REQ-013 D_MEM_CSN  output  1  data memory chip select, active-low.
REQ-014 HALT  output  1  sticky halted flag.
REQ-015 ILLEGAL  output  1  one-cycle pulse on an unrecognised opcode.
REQ-016 STATE  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALTED=5.
REQ-017 NUM_INST  output  CNT_W  count of retired instructions.

Function
REQ-018 The FSM SHALL leave IF for ID after exactly one cycle, and ID for EX after exactly one cycle unless REQ-025 or REQ-026 applies.
REQ-019 The FSM SHALL sequence ALU-R (0110011), ALU-I (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111) and JALR (1100111) as IF-ID-EX-WB (4 cycles).
REQ-020 The FSM SHALL sequence loads (0000011) as IF-ID-EX-MEM-WB (5 cycles).
REQ-021 The FSM SHALL sequence stores (0100011) as IF-ID-EX-MEM (4 cycles) and branches (1100011) as IF-ID-EX (3 cycles).
REQ-022 IR_WE SHALL be 1 only in IF; RF_WE SHALL be 1 only in WB; D_MEM_CSN SHALL be 0 only in MEM; D_MEM_WEN SHALL be 0 only in MEM of a store.
REQ-023 PC_WE SHALL be 1 only in the last cycle of each instruction (retire cycle): WB, store MEM, or branch EX.
REQ-024 PC_SRC SHALL be 01 when branch and BR_TAKEN=1, 10 for JAL, 11 for JALR, and 00 otherwise; it is meaningful only while PC_WE=1.
REQ-025 In ID with HALT_REQ=1, the FSM SHALL go to HALTED, set HALT=1, and not retire; HALTED is absorbing until reset, with all enables inactive.
REQ-026 In ID with an unrecognised opcode, the FSM SHALL pulse ILLEGAL, assert PC_WE with PC_SRC=00, retire, and return to IF.
REQ-027 NUM_INST SHALL increment by 1 on each cycle with PC_WE=1 and wrap from all-ones to 0.
REQ-028 All outputs SHALL be decoded from registered state and inputs only; there are no combinational loops through OPCODE.

Reset
REQ-029 While RSTn=0 at a rising edge: STATE=IF, HALT=0, NUM_INST=0, and ILLEGAL=0 on the next cycle.
REQ-030 While RSTn=0, IR_WE, PC_WE and RF_WE SHALL be 0, and D_MEM_WEN and D_MEM_CSN SHALL be 1.
REQ-031 Reset asserted mid-instruction, including in MEM or HALTED, SHALL abort the instruction with no retire.

Configuration
REQ-032 With macro RISCV_MC_CTRL_MEM_WAIT_EN defined, MEM SHALL hold while D_MEM_RDY=0, keeping the MEM outputs asserted, and exit on the first cycle with D_MEM_RDY=1.
REQ-033 Without RISCV_MC_CTRL_MEM_WAIT_EN, MEM SHALL last exactly one cycle, D_MEM_RDY SHALL be ignored, and the port SHALL remain present.

Verification
REQ-034 Reset, then ADD (0110011) -> STATE 0,1,2,4,0; RF_WE=1 only in cycle 4; PC_WE=1 in cycle 4 with PC_SRC=00; NUM_INST=1.
REQ-035 LW (0000011) then SW (0100011) -> 5 + 4 cycles; D_MEM_WEN=0 only in SW MEM; NUM_INST=2.
REQ-036 Branch with BR_TAKEN=1, then branch with BR_TAKEN=0 -> PC_SRC=01 then 00 in EX; each takes 3 cycles; RF_WE never 1.
REQ-037 JALR with HALT_REQ=1 in ID -> STATE=5, HALT=1, NUM_INST unchanged; RSTn=0 for one cycle -> STATE=0, HALT=0.
REQ-038 MEM_WAIT_EN defined, LW with D_MEM_RDY=0 for 3 cycles -> MEM lasts 4 cycles, total 8; undefined -> MEM lasts 1 cycle.
REQ-039 Opcode 0000000 -> ILLEGAL pulses in ID, PC_WE=1 with PC_SRC=00, NUM_INST+1; preload via 0xFFFFFFFF retires -> wraps to 0.

Source files
------------

// File: rtl/riscv_mc_ctrl_if.sv
// riscv_mc_ctrl_if -- control bundle between the multi-cycle RISC-V controller
// and its datapath.
//   slave  : controller side (riscv_mc_ctrl)
//   master : datapath / testbench side
// Signals:
//   OPCODE[6:0]   IR opcode field, valid from ID onward
//   BR_TAKEN      branch comparator result, valid in EX
//   HALT_REQ      halt condition from the datapath, sampled in ID
//   D_MEM_RDY     data memory ready (only honoured in the wait-state build)
//   IR_WE, PC_WE, PC_SRC[1:0], RF_WE, D_MEM_WEN (low), D_MEM_CSN (low)
//   HALT          sticky halted flag
//   ILLEGAL       one-cycle pulse on an unrecognised opcode
//   STATE[2:0]    IF=0 ID=1 EX=2 MEM=3 WB=4 HALTED=5
//   NUM_INST      retired-instruction counter, CNT_W bits
interface riscv_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       OPCODE;
    logic             BR_TAKEN;
    logic             HALT_REQ;
    logic             D_MEM_RDY;
    logic             IR_WE;
    logic             PC_WE;
    logic [1:0]       PC_SRC;
    logic             RF_WE;
    logic             D_MEM_WEN;
    logic             D_MEM_CSN;
    logic             HALT;
    logic             ILLEGAL;
    logic [2:0]       STATE;
    logic [CNT_W-1:0] NUM_INST;

    modport slave (
        input  OPCODE, BR_TAKEN, HALT_REQ, D_MEM_RDY,
        output IR_WE, PC_WE, PC_SRC, RF_WE, D_MEM_WEN, D_MEM_CSN,
               HALT, ILLEGAL, STATE, NUM_INST
    );

    modport master (
        output OPCODE, BR_TAKEN, HALT_REQ, D_MEM_RDY,
        input  IR_WE, PC_WE, PC_SRC, RF_WE, D_MEM_WEN, D_MEM_CSN,
               HALT, ILLEGAL, STATE, NUM_INST
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl -- multi-cycle RISC-V control FSM (IF/ID/EX/MEM/WB/HALTED).
// Ports:
//   CLK   clock, rising edge
//   RSTn  synchronous active-low reset
//   bus   riscv_mc_ctrl_if.slave (opcode/branch/halt/ready in, enables out)
// Parameter:
//   CNT_W width of the retired-instruction counter (must match bus)
// Build option:
//   RISCV_MC_CTRL_MEM_WAIT_EN -- when defined, MEM holds until D_MEM_RDY=1.
//   When undefined MEM is a single cycle and D_MEM_RDY is ignored.
module riscv_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    riscv_mc_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EX     = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_JAL, K_JALR, K_LOAD, K_STORE, K_BRANCH, K_ILL
    } kind_t;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           state_q;
    kind_t            kind_q;    // instruction class latched on ID->EX
    kind_t            kind_id;   // class decoded from OPCODE (used in ID)
    logic             halt_q;
    logic [CNT_W-1:0] num_q;
    logic             mem_done;
    logic             retire;

    always_comb begin
        kind_id = K_ILL;
        case (bus.OPCODE)
            OP_ALU_R, OP_ALU_I, OP_LUI, OP_AUIPC: kind_id = K_ALU;
            OP_JAL:    kind_id = K_JAL;
            OP_JALR:   kind_id = K_JALR;
            OP_LOAD:   kind_id = K_LOAD;
            OP_STORE:  kind_id = K_STORE;
            OP_BRANCH: kind_id = K_BRANCH;
            default:   kind_id = K_ILL;
        endcase
    end

`ifdef RISCV_MC_CTRL_MEM_WAIT_EN
    assign mem_done = bus.D_MEM_RDY;
`else
    logic unused_rdy;
    assign unused_rdy = bus.D_MEM_RDY;
    assign mem_done   = 1'b1;
`endif

    // Retire cycle: the last cycle of an instruction. Illegal opcodes retire
    // in ID, so this depends on OPCODE in ID; OPCODE comes from the IR, whose
    // load enable depends on state only, so no loop is formed.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_ID:    retire = !bus.HALT_REQ && (kind_id == K_ILL);
            S_EX:    retire = (kind_q == K_BRANCH);
            S_MEM:   retire = (kind_q == K_STORE) && mem_done;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    // Enables are gated by RSTn so they are inactive for the whole reset
    // period, including the cycle before the first reset edge.
    always_comb begin
        bus.IR_WE     = RSTn && (state_q == S_IF);
        bus.RF_WE     = RSTn && (state_q == S_WB);
        bus.D_MEM_CSN = !(RSTn && (state_q == S_MEM));
        bus.D_MEM_WEN = !(RSTn && (state_q == S_MEM) && (kind_q == K_STORE));
        bus.PC_WE     = RSTn && retire;
        bus.ILLEGAL   = RSTn && (state_q == S_ID) && !bus.HALT_REQ
                        && (kind_id == K_ILL);
        // BR_TAKEN is only valid in EX, so the branch select is decoded live.
        bus.PC_SRC    = 2'b00;
        if (state_q == S_EX && kind_q == K_BRANCH)
            bus.PC_SRC = {1'b0, bus.BR_TAKEN};
        else if (state_q == S_WB && kind_q == K_JAL)
            bus.PC_SRC = 2'b10;
        else if (state_q == S_WB && kind_q == K_JALR)
            bus.PC_SRC = 2'b11;
        bus.HALT      = halt_q;
        bus.STATE     = state_q;
        bus.NUM_INST  = num_q;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IF;
            kind_q  <= K_ALU;
            halt_q  <= 1'b0;
            num_q   <= '0;
        end else begin
            if (retire)
                num_q <= num_q + CNT_W'(1);
            case (state_q)
                S_IF: state_q <= S_ID;
                S_ID: begin
                    if (bus.HALT_REQ) begin
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                    end else if (kind_id == K_ILL) begin
                        state_q <= S_IF;
                    end else begin
                        kind_q  <= kind_id;
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    case (kind_q)
                        K_BRANCH:        state_q <= S_IF;
                        K_LOAD, K_STORE: state_q <= S_MEM;
                        default:         state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_done)
                        state_q <= (kind_q == K_LOAD) ? S_WB : S_IF;
                end
                S_WB:     state_q <= S_IF;
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    riscv_mc_ctrl_if #(.CNT_W(32)) bus ();
    riscv_mc_ctrl_if #(.CNT_W(3))  bus_s ();

    assign bus_s.OPCODE    = bus.OPCODE;
    assign bus_s.BR_TAKEN  = bus.BR_TAKEN;
    assign bus_s.HALT_REQ  = bus.HALT_REQ;
    assign bus_s.D_MEM_RDY = bus.D_MEM_RDY;

    riscv_mc_ctrl #(.CNT_W(32)) dut   (.CLK(CLK), .RSTn(RSTn), .bus(bus));
    riscv_mc_ctrl #(.CNT_W(3))  dut_s (.CLK(CLK), .RSTn(RSTn), .bus(bus_s));

`ifdef RISCV_MC_CTRL_MEM_WAIT_EN
    localparam bit MEM_WAIT = 1'b1;
`else
    localparam bit MEM_WAIT = 1'b0;
`endif

    localparam logic [6:0] ADD  = 7'b0110011, ADDI = 7'b0010011;
    localparam logic [6:0] LUI  = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL  = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LW   = 7'b0000011, SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir, pcwe;
        logic [1:0]  src;
        logic        rf, wen, csn, halt, ill;
        logic [31:0] num;
        logic [2:0]  nsm;
    } tr_t;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cnt   = 0;     // model retire count since last reset
    int  exp_st[$];
    tr_t exp_tr[$];
    tr_t obs_tr[$];

    function automatic tr_t sample();
        tr_t t;
        t.st   = bus.STATE;
        t.ir   = bus.IR_WE;
        t.pcwe = bus.PC_WE;
        t.src  = bus.PC_WE ? bus.PC_SRC : 2'b00;
        t.rf   = bus.RF_WE;
        t.wen  = bus.D_MEM_WEN;
        t.csn  = bus.D_MEM_CSN;
        t.halt = bus.HALT;
        t.ill  = bus.ILLEGAL;
        t.num  = bus.NUM_INST;
        t.nsm  = bus_s.NUM_INST;
        return t;
    endfunction

    // Reference: expand one instruction into its per-cycle state list, then
    // derive every output from the state, the class and "retire = last cycle".
    task automatic model_instr(input logic [6:0] op, input bit br,
                               input bit hreq, input int lo);
        bit ld, st, bra, jal, jalr, ill;
        int m;
        tr_t t;
        ld   = (op == LW);
        st   = (op == SW);
        bra  = (op == BEQ);
        jal  = (op == JAL);
        jalr = (op == JALR);
        ill  = !(ld || st || bra || jal || jalr || op == ADD || op == ADDI
                 || op == LUI || op == AUIPC);
        exp_st.delete();
        exp_tr.delete();
        exp_st.push_back(0);
        exp_st.push_back(1);
        if (hreq) begin
            repeat (3) exp_st.push_back(5);
        end else if (!ill) begin
            exp_st.push_back(2);
            if (ld || st) begin
                m = MEM_WAIT ? lo + 1 : 1;
                repeat (m) exp_st.push_back(3);
                if (ld) exp_st.push_back(4);
            end else if (!bra) begin
                exp_st.push_back(4);
            end
        end
        for (int k = 0; k < exp_st.size(); k++) begin
            bit ret;
            ret    = !hreq && (k == exp_st.size() - 1);
            t.st   = 3'(exp_st[k]);
            t.ir   = (exp_st[k] == 0);
            t.pcwe = ret;
            t.src  = !ret ? 2'b00 : bra ? {1'b0, br} : jal ? 2'b10
                   : jalr ? 2'b11 : 2'b00;
            t.rf   = (exp_st[k] == 4);
            t.wen  = !(exp_st[k] == 3 && st);
            t.csn  = !(exp_st[k] == 3);
            t.halt = (exp_st[k] == 5);
            t.ill  = ill && !hreq && (exp_st[k] == 1);
            t.num  = 32'(cnt);
            t.nsm  = 3'(cnt);
            exp_tr.push_back(t);
        end
        if (!hreq) cnt++;
    endtask

    // Drives the model's phases; inputs outside their valid phase are random.
    task automatic exec_instr(input logic [6:0] op, input bit br,
                              input bit hreq, input int lo, input int ncyc);
        int mem_seen = 0;
        obs_tr.delete();
        for (int k = 0; k < ncyc; k++) begin
            bus.OPCODE   = (exp_st[k] == 0) ? 7'($urandom) : op;
            bus.BR_TAKEN = (exp_st[k] == 2) ? br : 1'($urandom);
            bus.HALT_REQ = (exp_st[k] == 1) ? hreq : 1'($urandom);
            if (exp_st[k] == 3) begin
                bus.D_MEM_RDY = (mem_seen >= lo);
                mem_seen++;
            end else begin
                bus.D_MEM_RDY = 1'($urandom);
            end
            @(negedge CLK);
            obs_tr.push_back(sample());
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset(input string nm);
        tr_t t;
        RSTn = 1'b0;
        bus.HALT_REQ = 1'b1;
        bus.OPCODE   = 7'b0000000;
        @(negedge CLK);
        t = sample();
        n_cmp++;
        if ({t.ir, t.pcwe, t.rf, t.wen, t.csn} !== 5'b00011) begin
            n_err++;
            $display("FAIL %s_enables_in_reset got=%b exp=00011", nm,
                     {t.ir, t.pcwe, t.rf, t.wen, t.csn});
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        t = sample();
        n_cmp++;
        if ({t.st, t.halt, t.ill, t.num, t.nsm, t.ir, t.pcwe, t.rf, t.wen, t.csn}
            !== {3'd0, 1'b0, 1'b0, 32'd0, 3'd0, 5'b00011}) begin
            n_err++;
            $display("FAIL %s_after_edge got st=%0d halt=%b ill=%b num=%0d nsm=%0d exp 0/0/0/0/0",
                     nm, t.st, t.halt, t.ill, t.num, t.nsm);
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        cnt  = 0;
    endtask

    task automatic test_add();
        model_instr(ADD, 1'b0, 1'b0, 0);
        exec_instr(ADD, 1'b0, 1'b0, 0, exp_st.size());
        for (int k = 0; k < obs_tr.size(); k++) begin
            n_cmp++;
            if (obs_tr[k] !== exp_tr[k]) begin
                n_err++;
                $display("FAIL add cyc%0d got=%h exp=%h", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_load_store();
        logic [6:0] ops [2] = '{LW, SW};
        foreach (ops[i]) begin
            model_instr(ops[i], 1'b0, 1'b0, 0);
            exec_instr(ops[i], 1'b0, 1'b0, 0, exp_st.size());
            for (int k = 0; k < obs_tr.size(); k++) begin
                n_cmp++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    n_err++;
                    $display("FAIL ldst op=%b cyc%0d got=%h exp=%h", ops[i], k,
                             obs_tr[k], exp_tr[k]);
                end
            end
        end
    endtask

    task automatic test_branch();
        for (int b = 1; b >= 0; b--) begin
            model_instr(BEQ, 1'(b), 1'b0, 0);
            exec_instr(BEQ, 1'(b), 1'b0, 0, exp_st.size());
            for (int k = 0; k < obs_tr.size(); k++) begin
                n_cmp++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    n_err++;
                    $display("FAIL branch taken=%0d cyc%0d got=%h exp=%h", b, k,
                             obs_tr[k], exp_tr[k]);
                end
            end
        end
    endtask

    task automatic test_jumps();
        logic [6:0] ops [5] = '{JAL, JALR, LUI, AUIPC, ADDI};
        foreach (ops[i]) begin
            model_instr(ops[i], 1'b1, 1'b0, 0);
            exec_instr(ops[i], 1'b1, 1'b0, 0, exp_st.size());
            for (int k = 0; k < obs_tr.size(); k++) begin
                n_cmp++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    n_err++;
                    $display("FAIL jump op=%b cyc%0d got=%h exp=%h", ops[i], k,
                             obs_tr[k], exp_tr[k]);
                end
            end
        end
    endtask

    // Ten illegal retires also carry the 3-bit counter through 7 -> 0.
    task automatic test_illegal();
        logic [6:0] op;
        for (int n = 0; n < 10; n++) begin
            op = (n == 0) ? 7'b0000000 : (n % 2 == 1) ? 7'b1111111 : 7'b0001111;
            model_instr(op, 1'b0, 1'b0, 0);
            exec_instr(op, 1'b0, 1'b0, 0, exp_st.size());
            for (int k = 0; k < obs_tr.size(); k++) begin
                n_cmp++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    n_err++;
                    $display("FAIL illegal n=%0d cyc%0d got=%h exp=%h", n, k,
                             obs_tr[k], exp_tr[k]);
                end
            end
        end
    endtask

    task automatic test_mem_wait();
        model_instr(LW, 1'b0, 1'b0, 3);
        exec_instr(LW, 1'b0, 1'b0, 3, exp_st.size());
        for (int k = 0; k < obs_tr.size(); k++) begin
            n_cmp++;
            if (obs_tr[k] !== exp_tr[k]) begin
                n_err++;
                $display("FAIL memwait_lw cyc%0d got=%h exp=%h", k, obs_tr[k], exp_tr[k]);
            end
        end
        model_instr(SW, 1'b0, 1'b0, 2);
        exec_instr(SW, 1'b0, 1'b0, 2, exp_st.size());
        for (int k = 0; k < obs_tr.size(); k++) begin
            n_cmp++;
            if (obs_tr[k] !== exp_tr[k]) begin
                n_err++;
                $display("FAIL memwait_sw cyc%0d got=%h exp=%h", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pool [12] = '{ADD, ADDI, LUI, AUIPC, JAL, JALR, LW, SW, BEQ,
                                  7'b0000000, 7'b1111111, 7'b0101010};
        logic [6:0] op;
        bit br;
        int lo;
        for (int n = 0; n < 40; n++) begin
            op = pool[$urandom_range(0, 11)];
            br = 1'($urandom);
            lo = $urandom_range(0, 3);
            model_instr(op, br, 1'b0, lo);
            exec_instr(op, br, 1'b0, lo, exp_st.size());
            for (int k = 0; k < obs_tr.size(); k++) begin
                n_cmp++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    n_err++;
                    $display("FAIL b2b n=%0d op=%b cyc%0d got=%h exp=%h", n, op, k,
                             obs_tr[k], exp_tr[k]);
                end
            end
        end
    endtask

    task automatic test_halt();
        model_instr(JALR, 1'b0, 1'b1, 0);
        exec_instr(JALR, 1'b0, 1'b1, 0, exp_st.size());
        for (int k = 0; k < obs_tr.size(); k++) begin
            n_cmp++;
            if (obs_tr[k] !== exp_tr[k]) begin
                n_err++;
                $display("FAIL halt cyc%0d got=%h exp=%h", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    // Load interrupted by reset while in MEM: only IF/ID/EX are observed.
    task automatic test_abort();
        model_instr(LW, 1'b0, 1'b0, 0);
        exec_instr(LW, 1'b0, 1'b0, 0, 3);
        for (int k = 0; k < obs_tr.size(); k++) begin
            n_cmp++;
            if (obs_tr[k] !== exp_tr[k]) begin
                n_err++;
                $display("FAIL abort cyc%0d got=%h exp=%h", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    initial begin
        bus.OPCODE    = 7'd0;
        bus.BR_TAKEN  = 1'b0;
        bus.HALT_REQ  = 1'b0;
        bus.D_MEM_RDY = 1'b1;
        @(posedge CLK); #1;
        test_reset("por");
        test_add();
        test_load_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_mem_wait();
        test_back_to_back();
        test_abort();
        test_reset("abort");
        test_add();
        test_halt();
        test_reset("from_halt");
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
